// File: rtl/jt49_busq.sv
// AY-3-8910 BDIR/BC1 bus front end for up to four jt49 cores. Writes are queued in a
// FIFO and issued one per clk_en pulse. Define JT49_BUSQ_OVF_EN for a sticky overflow flag.
module jt49_busq #(
  parameter int         CHIPS     = 1,
  parameter logic [3:0] CHIP_BASE = 4'd0,
  parameter int         FIFO_AW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic               bdir,
  input  logic               bc1,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic               busy,
  output logic               ovf,
  output logic [CHIPS-1:0]   chip_cs_n,
  output logic               chip_wr_n,
  output logic [3:0]         chip_addr,
  output logic [7:0]         chip_din,
  input  logic [8*CHIPS-1:0] chip_dout
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [1:0] PH_READ  = 2'b01;
  localparam logic [1:0] PH_WRITE = 2'b10;
  localparam logic [1:0] PH_LATCH = 2'b11;

  typedef enum logic {IDLE, ISSUE} state_t;
  typedef struct packed {
    logic [1:0] chip;
    logic [3:0] addr;
    logic [7:0] data;
  } entry_t;

  state_t           state, state_nx;
  logic [1:0]       phase, prev;
  logic [3:0]       addr_r, sel_diff;
  logic [1:0]       sel_r;
  logic             sel_ok;
  logic [7:0]       wdat;
  entry_t           mem [DEPTH];
  entry_t           head;
  logic [FIFO_AW:0] wp, rp, wp_nx, rp_nx;
  logic             empty, full, wr_exit, push, pop;
  logic [CHIPS-1:0] cs_n_nx;
  logic             wr_n_nx, busy_nx;
  logic [3:0]       addr_nx;
  logic [7:0]       din_nx, rd_mux;

  assign phase    = {bdir, bc1};
  assign sel_diff = din[7:4] - CHIP_BASE;
  assign empty    = (wp == rp);
  assign full     = (wp[FIFO_AW] != rp[FIFO_AW]) && (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
  assign wr_exit  = (prev == PH_WRITE) && (phase != PH_WRITE) && sel_ok;
  // fullness is judged before any same-cycle pop, so a push into a full FIFO is dropped
  assign push     = wr_exit && !full;
  assign head     = mem[rp[FIFO_AW-1:0]];
  assign wp_nx    = wp + (FIFO_AW+1)'(push);
  assign rp_nx    = rp + (FIFO_AW+1)'(pop);
  assign busy_nx  = (wp_nx != rp_nx) || (state_nx == ISSUE);

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: if (!empty && clk_en && phase != PH_READ) begin
        state_nx = ISSUE;
        pop      = 1'b1;
      end
      ISSUE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cs_n_nx = '1;
    wr_n_nx = 1'b1;
    addr_nx = chip_addr;
    din_nx  = chip_din;
    if (pop) begin
      for (int k = 0; k < CHIPS; k++)
        if (head.chip == 2'(k)) cs_n_nx[k] = 1'b0;
      wr_n_nx = 1'b0;
      addr_nx = head.addr;
      din_nx  = head.data;
    end else if (phase == PH_READ && sel_ok && empty && state == IDLE) begin
      for (int k = 0; k < CHIPS; k++)
        if (sel_r == 2'(k)) cs_n_nx[k] = 1'b0;
      addr_nx = addr_r;
    end
  end

  always_comb begin
    rd_mux = 8'hFF;
    for (int k = 0; k < CHIPS; k++)
      if (sel_r == 2'(k)) rd_mux = chip_dout[8*k +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev      <= 2'b00;
      wp        <= '0;
      rp        <= '0;
      addr_r    <= 4'd0;
      sel_r     <= 2'd0;
      sel_ok    <= 1'b1;
      wdat      <= 8'd0;
      chip_cs_n <= '1;
      chip_wr_n <= 1'b1;
      chip_addr <= 4'd0;
      chip_din  <= 8'd0;
      dout      <= 8'd0;
      busy      <= 1'b0;
    end else begin
      state <= state_nx;
      prev  <= phase;
      wp    <= wp_nx;
      rp    <= rp_nx;
      if (phase == PH_LATCH) begin
        addr_r <= din[3:0];
        sel_ok <= sel_diff < 4'(CHIPS);
        sel_r  <= sel_diff[1:0];
      end
      if (phase == PH_WRITE) wdat <= din;
      chip_cs_n <= cs_n_nx;
      chip_wr_n <= wr_n_nx;
      chip_addr <= addr_nx;
      chip_din  <= din_nx;
      dout      <= sel_ok ? rd_mux : 8'hFF;
      busy      <= busy_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[FIFO_AW-1:0]] <= {sel_r, addr_r, wdat};
  end

`ifdef JT49_BUSQ_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ovf <= 1'b0;
    else if (wr_exit && full)  ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
